// File: rtl/mem_arbiter.sv
// Arbiter sharing one variable-latency RAM port between instruction fetch and data access.
// Data has strict priority; one transaction in flight, with a watchdog that forces a sticky error.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] INSTR = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic          wr_q, wr_d;
    logic          access;

    assign access = (ramstate == RAM_ACCESS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        store_d = store_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (dREN || dWEN) begin
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                    state_d = DATA;
                end else if (iREN) begin
                    addr_d  = iaddr;
                    state_d = INSTR;
                end
            end
            DATA, INSTR: begin
                // Completion beats both the RAM fault and the watchdog in the same cycle.
                if (access) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    state_d = ERR;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = addr_q;
        ramstore = store_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        err      = (state_q == ERR);
        case (state_q)
            DATA: begin
                ramWEN = wr_q;
                ramREN = !wr_q;
                if (access) begin
                    dwait = 1'b0;
                    if (!wr_q) dload = ramload;
                end
            end
            INSTR: begin
                ramREN = 1'b1;
                if (access) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing a single-ported, variable-latency RAM between the instruction-fetch and data-access ports of the processor datapath. Data accesses have priority over fetches. The grant state machine holds one transaction in flight and latches its address and write data at grant. A watchdog counter converts a stalled RAM into a sticky error. It sits between the datapath's imem/dmem request signals (imemREN, dmemREN, dmemWEN) and the RAM model.

## Interface
- TIMEOUT, 64: maximum cycles a granted transaction may wait for RAM ACCESS before entering ERR (>=2)
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- iload  out  32  instruction data
- iwait  out  1  low only in the instruction completion cycle
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data word address
- dstore  in  32  write data
- dload  out  32  read data
- dwait  out  1  low only in the data completion cycle
- ramREN / ramWEN  out  1 / 1  RAM strobes
- ramaddr  out  32  latched transaction address
- ramstore  out  32  latched write data
- ramload  in  32  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err  out  1  sticky fault flag

## Operation
- States: IDLE, DATA, INSTR, ERR.
- IDLE:
  - If dREN|dWEN: latch daddr, dstore and the write bit (dWEN wins if both dREN and dWEN are set), then go to DATA.
  - Else if iREN: latch iaddr, then go to INSTR.
  - Else stay in IDLE.
  - RAM strobes are low.
- DATA:
  - ramWEN = latched write bit; ramREN = its inverse.
  - ramaddr and ramstore come from the latches.
- INSTR: ramREN=1, ramWEN=0, ramaddr = latched iaddr.
- Completion cycle, in DATA or INSTR with ramstate==ACCESS:
  - Owner's wait output is 0 (dwait or iwait).
  - For reads, dload or iload = ramload, combinationally.
  - Next state IDLE.
  - Completion occurs even if the requester has dropped its request.
- ramstate==ERROR in DATA or INSTR: next state ERR.
- Watchdog:
  - busy_cnt is $clog2(TIMEOUT+1) bits and is cleared in IDLE.
  - It increments each DATA/INSTR cycle without ACCESS.
  - If busy_cnt==TIMEOUT-1 and there is no ACCESS, next state is ERR.
- ERR:
  - Strobes low, iwait=dwait=1, err=1.
  - Left only by RST.
- Non-owner wait is always 1; iload/dload = 0 outside their own completion cycle.
- Priority is strict data-first: a pending fetch is taken only when no data request is present in IDLE.

## Timing
- Reset values (cycle after RST high): state IDLE, busy_cnt 0, latches 0.
  - Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0, err=0.
- RST asserted mid-transaction: strobes drop at the next edge and the transaction is abandoned with no completion pulse. RST overrides ERR.
- Latency:
  - Request sampled in IDLE at edge N; strobes active from N+1.
  - Completion is the first cycle with ACCESS, k>=N+1.
  - Back in IDLE at k+1; the next grant is sampled at k+1, so strobes resume at k+2.
  - Minimum request-to-completion is 2 cycles; there is one mandatory IDLE bubble between transactions.
- Latched address/data are stable for the whole transaction; requester changes after grant are ignored.
- A request arriving in the completion cycle is not granted until the following IDLE cycle.
- Timeout: with the grant at edge N and no ACCESS, ERR is entered at edge N+TIMEOUT; the last cycle on which ACCESS still completes is N+TIMEOUT-1.

## Test plan
- RST, then iREN=1, iaddr=0x40, ramstate ACCESS on the first strobe cycle, ramload=0x3C010001:
  - ramREN=1 and ramaddr=0x40 in cycle 1.
  - iwait=0 and iload=0x3C010001 in that same cycle.
  - IDLE next.
- iREN and dWEN both raised at the same cycle, daddr=0x80, dstore=0xDEADBEEF, RAM BUSY 3 cycles then ACCESS:
  - Data is granted first: ramWEN=1, ramstore=0xDEADBEEF, dwait=0 on the 4th strobe cycle.
  - Instruction fetch is granted after one IDLE bubble.
- Data read with daddr changed to 0x100 one cycle after grant (original 0xFC): ramaddr stays 0xFC until completion.
- TIMEOUT=4, ramstate stuck BUSY:
  - err=1 and both waits high from the edge 4 cycles after grant.
  - Later ACCESS is ignored; RST clears err.
- ramstate=ERROR during an instruction fetch: ERR next cycle, err=1, iwait never low.
- RST pulsed during a BUSY data write:
  - ramWEN=0 the next cycle, no dwait=0 pulse.
  - A fresh dREN is granted normally afterwards.
